// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_if -- parallel-word handshake bundle plus the serial line of one UART
// direction.
//   data  : word to send (producer -> transmitter)
//   valid : producer has a word (producer -> transmitter)
//   ready : transmitter idle and able to accept (transmitter -> producer)
//   sig   : serial line, idle high (transmitter -> pad)
// Modport tx is the transmitter side.
// ---------------------------------------------------------------------------
interface uart_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  sig;

    modport tx (
        input  data,
        input  valid,
        output ready,
        output sig
    );
endinterface

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- UART transmitter. Accepts one word per valid/ready handshake on
// txif and sends it as a start bit, DATA_WIDTH data bits LSB first, and a
// stop bit. Each bit lasts PULSE_WIDTH = CLK_FREQ / BAUD_RATE clocks.
//
// Ports:
//   clk   : sole clock, rising edge
//   rstn  : synchronous reset, active HIGH (rstn = 1 resets)
//   txif  : uart_if.tx -- data/valid in, ready/sig out (both registered)
//
// Build option:
//   UART_TX_PARITY_EN -- when defined, an even-parity bit (XOR of the data
//   bits) follows the last data bit and the frame grows by one bit-time.
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic clk,
    input  logic rstn,
    uart_if.tx   txif
);

    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    // Guard against zero-width counters for degenerate parameter choices.
    localparam int TW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(PULSE_WIDTH - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         idx_q,   idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sig_q,   sig_d;
    logic                  ready_q, ready_d;

    logic                  tick;
    logic [IW-1:0]         idx_nxt;

    assign tick    = (timer_q == T_LAST);
    assign idx_nxt = idx_q + IW'(1);

    // Outputs are computed one cycle ahead (sig_d/ready_d) so that the line
    // level for each bit is launched straight from a flop on the edge that
    // starts the bit.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        sig_d   = sig_q;
        ready_d = ready_q;

        if (state_q != IDLE) begin
            timer_d = tick ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (txif.valid && ready_q) begin
                    shreg_d = txif.data;
                    timer_d = '0;
                    idx_d   = '0;
                    sig_d   = 1'b0;
                    ready_d = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    sig_d   = shreg_q[0];
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == I_LAST) begin
`ifdef UART_TX_PARITY_EN
                        sig_d   = ^shreg_q;
                        state_d = PARITY;
`else
                        sig_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_nxt;
                        sig_d = shreg_q[idx_nxt];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    sig_d   = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // ready rises on the edge that ends the stop bit; a held
                // valid is then taken on the following edge.
                if (tick) begin
                    sig_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                sig_d   = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            sig_q   <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            sig_q   <= sig_d;
            ready_q <= ready_d;
        end
    end

    assign txif.sig   = sig_q;
    assign txif.ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- scoreboard bench for uart_tx. Two instances share the clock:
// one at the default 868 clocks/bit, one with 5 clocks/bit for the longer
// sequences. Stimulus pushes each frame's expected line bits into a queue;
// a monitor per instance detects start bits, samples mid-bit and compares.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int PWD   = 868;
    localparam int PWF   = 5;      // 1000 / 200
    localparam int BOUND = 20000;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [NB-1:0] A5_FR = 11'b1_0_10100101_0;
`else
    localparam int NB = 10;
    localparam logic [NB-1:0] A5_FR = 10'b1_10100101_0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst, vld, rdy, sig;
    logic [1:0][7:0] dat;

    uart_if #(.DATA_WIDTH(8)) if_d ();
    uart_if #(.DATA_WIDTH(8)) if_f ();

    assign if_d.data  = dat[0];
    assign if_d.valid = vld[0];
    assign if_f.data  = dat[1];
    assign if_f.valid = vld[1];
    assign rdy[0] = if_d.ready;
    assign sig[0] = if_d.sig;
    assign rdy[1] = if_f.ready;
    assign sig[1] = if_f.sig;

    uart_tx u_def (
        .clk  (clk),
        .rstn (rst[0]),
        .txif (if_d)
    );

    uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(200), .CLK_FREQ(1000)) u_fast (
        .clk  (clk),
        .rstn (rst[1]),
        .txif (if_f)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic q0[$];
    logic q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out after %0d cycles", nm, BOUND);
    endtask

    function automatic logic [NB-1:0] mk_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic push_frame(input int w, input logic [NB-1:0] fr);
        for (int i = 0; i < NB; i++) begin
            if (w == 1) q1.push_back(fr[i]);
            else        q0.push_back(fr[i]);
        end
    endtask

    // Wait (at negedges) until ready equals val.
    task automatic wait_rdy(input int w, input logic val, input string nm);
        int t = 0;
        while (rdy[w] !== val && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        if (rdy[w] !== val) timeout(nm);
    endtask

    // Handshake one word; returns at the first negedge after the accept edge.
    task automatic accept(input int w, input logic [7:0] d, input logic [NB-1:0] fr);
        @(negedge clk);
        wait_rdy(w, 1'b1, "accept_wait_ready");
        dat[w] = d;
        vld[w] = 1'b1;
        push_frame(w, fr);
        @(negedge clk);
        wait_rdy(w, 1'b0, "accept_wait_busy");
        vld[w] = 1'b0;
    endtask

    // Counts further negedges with ready low until it rises.
    task automatic wait_idle(input int w, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy[w] || n >= BOUND) break;
            n++;
        end
        if (!rdy[w]) timeout("wait_idle");
    endtask

    task automatic send(input int w, input logic [7:0] d, input logic [NB-1:0] fr, output int low);
        int n;
        accept(w, d, fr);
        wait_idle(w, n);
        low = n + 1;
    endtask

    task automatic monitor(input int w, input int pw);
        logic prev = 1'b1;
        logic cur;
        logic exp_b;
        bit   ab;
        int   nw;
        forever begin
            @(negedge clk);
            cur = sig[w];
            if (prev && !cur && !rst[w]) begin
                ab = 1'b0;
                for (int b = 0; b < NB && !ab; b++) begin
                    nw = (b == 0) ? pw / 2 : pw;
                    for (int c = 0; c < nw; c++) begin
                        @(negedge clk);
                        if (rst[w]) ab = 1'b1;
                    end
                    if (!ab) begin
                        if ((w == 1 ? q1.size() : q0.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame_bit inst%0d bit%0d: got %b required none", w, b, sig[w]);
                        end else begin
                            exp_b = (w == 1) ? q1.pop_front() : q0.pop_front();
                            chk($sformatf("frame_bit inst%0d bit%0d", w, b), 32'(sig[w]), 32'(exp_b));
                        end
                    end
                end
                if (ab) begin
                    if (w == 1) q1.delete();
                    else        q0.delete();
                end
                cur = sig[w];
            end
            prev = cur;
        end
    endtask

    initial monitor(0, PWD);
    initial monitor(1, PWF);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int n;
        int t1;
        int t2;
        int hi;

        rst = 2'b11;
        vld = 2'b00;
        dat = '0;

        // Reset held for 10 clocks, then idle with valid low.
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            chk("reset_sig", 32'(sig), 32'h3);
            chk("reset_ready", 32'(rdy), 32'h3);
        end
        rst = 2'b00;
        repeat (20) begin
            @(negedge clk);
            chk("idle_sig", 32'(sig), 32'h3);
            chk("idle_ready", 32'(rdy), 32'h3);
        end

        // Single frame 0xA5 at default bit rate.
        send(0, 8'hA5, A5_FR, low);
        chk("a5_ready_low", 32'(low), 32'(NB * PWD));

        // Exhaustive sweep on the fast instance.
        for (int i = 0; i < 256; i++) begin
            send(1, 8'(i), mk_frame(8'(i)), low);
            chk($sformatf("sweep_ready_low %02h", i), 32'(low), 32'(NB * PWF));
        end

        // Data stability and ignored mid-frame valid.
        accept(1, 8'h00, mk_frame(8'h00));
        dat[1] = 8'hFF;
        repeat (20) @(negedge clk);
        vld[1] = 1'b1;
        @(negedge clk);
        chk("busy_ready0", 32'(rdy[1]), 32'h0);
        vld[1] = 1'b0;
        @(negedge clk);
        chk("busy_ready1", 32'(rdy[1]), 32'h0);
        wait_idle(1, n);
        chk("stable_ready_low", 32'(n + 23), 32'(NB * PWF));
        repeat (3 * PWF) @(negedge clk);
        chk("no_extra_accept", 32'(rdy[1]), 32'h1);

        // Reset during data bit 3 of 0x00.
        accept(1, 8'h00, mk_frame(8'h00));
        repeat (4 * PWF) @(negedge clk);
        chk("mid_frame_d3", 32'(sig[1]), 32'h0);
        rst[1] = 1'b1;
        @(negedge clk);
        chk("midrst_sig", 32'(sig[1]), 32'h1);
        chk("midrst_ready", 32'(rdy[1]), 32'h1);
        @(negedge clk);
        rst[1] = 1'b0;
        send(1, 8'h5A, mk_frame(8'h5A), low);
        chk("post_rst_ready_low", 32'(low), 32'(NB * PWF));

        // Back-to-back with valid held high.
        @(negedge clk);
        wait_rdy(1, 1'b1, "b2b_wait_ready");
        dat[1] = 8'h3C;
        vld[1] = 1'b1;
        push_frame(1, mk_frame(8'h3C));
        @(negedge clk);
        wait_rdy(1, 1'b0, "b2b_accept1");
        t1 = cyc;
        dat[1] = 8'hC3;
        push_frame(1, mk_frame(8'hC3));
        wait_rdy(1, 1'b1, "b2b_ready_rise");
        hi = 0;
        while (rdy[1] && hi < BOUND) begin
            hi++;
            @(negedge clk);
        end
        t2 = cyc;
        vld[1] = 1'b0;
        chk("b2b_ready_high", 32'(hi), 32'h1);
        chk("b2b_spacing", 32'(t2 - t1), 32'(NB * PWF + 1));
        wait_idle(1, n);
        chk("b2b_ready_low2", 32'(n + 1), 32'(NB * PWF));

        repeat (10) @(negedge clk);
        chk("queue0_empty", 32'(q0.size()), 32'h0);
        chk("queue1_empty", 32'(q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the UART block. It accepts one parallel word per valid/ready handshake on the `uart_if` bundle and serialises it as one 8N1 frame on the serial line: start bit, data LSB first, stop bit. The bit timing comes from a clock divider derived from `CLK_FREQ / BAUD_RATE`. It sits between the host-side producer and the `txif.sig` pad.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `CLK_FREQ`, default 100_000_000: `clk` frequency in Hz.
- Derived `PULSE_WIDTH = CLK_FREQ / BAUD_RATE`, using integer division (868 at the defaults): clocks per bit.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rstn`  in  1  reset. Synchronous, active-high: `rstn = 1` resets.
- `txif`  `uart_if #(DATA_WIDTH)` bundle, tx side:
  - `txif.data`  in  `DATA_WIDTH`  word to send.
  - `txif.valid`  in  1  producer has a word.
  - `txif.ready`  out  1  block idle, can accept.
  - `txif.sig`  out  1  serial line, idle high.

## Operation
- States: IDLE → START → DATA → STOP → IDLE (PARITY between DATA and STOP when enabled).
- **IDLE:**
  - `ready = 1`, `sig = 1`.
  - On a rising edge with `valid & ready`: capture `data` into the shift register, clear the bit-timer and bit-index, and go to START.
- **START:** `sig = 0` for `PULSE_WIDTH` clocks.
- **DATA:**
  - `sig = data[i]` for i = 0 … `DATA_WIDTH-1`, LSB first.
  - Each bit lasts `PULSE_WIDTH` clocks.
  - The index counter is `$clog2(DATA_WIDTH)` bits wide and does not wrap within a frame.
- **STOP:** `sig = 1` for `PULSE_WIDTH` clocks, then return to IDLE.
- Bit timer:
  - Counts 0 … `PULSE_WIDTH-1`, then wraps to 0 and advances the bit.
  - Width is `$clog2(PULSE_WIDTH)`.
- `ready = 0` in every state except IDLE.
- `valid` is ignored while busy.
- `data` changes after the handshake do not affect the frame in flight.
- `valid` held high continuously: frames are sent back-to-back, each re-accepting the current `data`.
- Reset:
  - Outputs `sig = 1`, `ready = 1`; state IDLE; counters cleared.
  - Reset mid-frame aborts the frame; `sig` returns high on the reset edge.

## Timing
- Accept edge T: `ready` and `sig` are both registered.
  - `ready` falls at T.
  - `sig` falls to the start bit at T.
- Bit k (start = 0, data = 1 … `DATA_WIDTH`, stop = `DATA_WIDTH+1`) occupies edges `T + k·PULSE_WIDTH` up to `T + (k+1)·PULSE_WIDTH`.
- `ready` rises at `T + (DATA_WIDTH+2)·PULSE_WIDTH`, the end of the stop bit.
  - If `valid` is high in that cycle, the next accept happens on the following edge.
  - Minimum frame spacing is therefore `(DATA_WIDTH+2)·PULSE_WIDTH + 1` clocks.
- A sample taken `PULSE_WIDTH/2` clocks into each bit must see a stable value.
- Outputs are glitch-free: `sig` is driven from a flop.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined:
  - An even-parity bit (XOR of all data bits) is inserted after the last data bit, lasting `PULSE_WIDTH` clocks.
  - The frame becomes `DATA_WIDTH+3` bits.
  - `ready` returns one bit-time later.
- Undefined:
  - No parity state; 8N1 frame exactly as above.
  - This is the default build.

## Test plan
- **Reset:** hold `rstn = 1` for 10 clocks, then release.
  - `sig = 1` and `ready = 1` throughout and after.
  - No transition on `sig` while `valid = 0`.
- **Single frame:** send `data = 8'hA5` (defaults, 868 clocks/bit), sampling at mid-bit.
  - Sampled sequence: 0, 1,0,1,0,0,1,0,1, 1.
  - `ready` low exactly 8680 clocks after acceptance.
- **Exhaustive sweep:** send `data` 0x00 … 0xFF, each after `ready` rises, with `valid` dropped once `ready` falls.
  - Every mid-bit sample matches start = 0, LSB-first data, stop = 1.
- **Data stability:** change `txif.data` to 0xFF one clock after accepting 0x00.
  - Line still carries eight zero data bits.
  - Second `valid` pulse mid-frame is ignored; `ready` stays 0.
- **Reset mid-frame:** assert `rstn` during data bit 3 of 0x00.
  - `sig = 1` and `ready = 1` on the next edge.
  - Next handshake starts a clean frame.
- **Back-to-back:** hold `valid = 1` with 0x3C then 0xC3.
  - Second start bit begins exactly one clock after `ready` rises.
  - With `UART_TX_PARITY_EN`, parity bits are 0 and 0.
